// File: rtl/byte_swap_arbiter_if.sv
// byte_swap_arbiter_if: two-requester handshake plus result channel of the swap arbiter
interface byte_swap_arbiter_if #(parameter int DATA_W = 16);
  logic              req0_valid, req0_ready, req1_valid, req1_ready;
  logic [DATA_W-1:0] req0_data, req1_data, out_data;
  logic              out_valid, out_ready, out_id;
  modport master(
    output req0_valid, req0_data, req1_valid, req1_data, out_ready,
    input  req0_ready, req1_ready, out_valid, out_data, out_id
  );
  modport slave(
    input  req0_valid, req0_data, req1_valid, req1_data, out_ready,
    output req0_ready, req1_ready, out_valid, out_data, out_id
  );
endinterface

// File: rtl/byte_swap_arbiter.sv
// byte_swap_arbiter: round-robin accept of one word, swap its halves, hand it out
module byte_swap_arbiter #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 8
) (
  input  logic               clk,
  input  logic               rst,
  byte_swap_arbiter_if.slave bus,
  output logic               busy,
  output logic [CNT_W-1:0]   swap_count
);
  localparam int H = DATA_W / 2;
  if (DATA_W % 2 != 0) begin : g_odd
    $error("DATA_W must be even");
  end
  typedef enum logic [1:0] {IDLE, SWAP, DONE} state_t;
  state_t            state_q, state_d;
  logic [DATA_W-1:0] temp_q, temp_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              id_q, id_d, last_q, last_d, out_valid_q, busy_q, g0, g1;
  // grant: lone valid wins, a tie goes to the requester not served last
  always_comb begin
    g0 = state_q == IDLE && !rst && bus.req0_valid && (!bus.req1_valid || last_q);
    g1 = state_q == IDLE && !rst && bus.req1_valid && (!bus.req0_valid || !last_q);
  end
  assign bus.req0_ready = g0;
  assign bus.req1_ready = g1;
  // next state: capture on accept, swap halves once, release on output handshake
  always_comb begin
    state_d = state_q;
    temp_d  = temp_q;
    id_d    = id_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    if (g0 || g1) begin
      state_d = SWAP;
      temp_d  = g1 ? bus.req1_data : bus.req0_data;
      id_d    = g1;
      last_d  = g1;
    end else if (state_q == SWAP) begin
      state_d = DONE;
      temp_d  = {temp_q[H-1:0], temp_q[DATA_W-1:H]};
    end else if (state_q == DONE && bus.out_ready) begin
      state_d = IDLE;
      cnt_d   = cnt_q + CNT_W'(1);
    end
  end
  // state and registered status; reset wins over any handshake on the same edge
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      temp_q      <= '0;
      id_q        <= 1'b0;
      last_q      <= 1'b1;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      temp_q      <= temp_d;
      id_q        <= id_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      out_valid_q <= state_d == DONE;
      busy_q      <= state_d != IDLE;
    end
  end
  // outputs are forced quiet for the whole time rst is held
  assign bus.out_valid = out_valid_q && !rst;
  assign bus.out_data  = rst ? '0 : temp_q;
  assign bus.out_id    = id_q;
  assign busy          = busy_q && !rst;
  assign swap_count    = cnt_q;
endmodule

// File: tb/tb_byte_swap_arbiter.sv
// tb_byte_swap_arbiter: scoreboard bench for the byte swap arbiter
module tb_byte_swap_arbiter;
  logic        clk = 0;
  logic        rst = 1;
  logic        busy;
  logic [7:0]  swap_count;
  logic [7:0]  exp_cnt = 0;
  logic [16:0] q[$];
  int          n_chk = 0;
  int          n_fail = 0;
  byte_swap_arbiter_if #(.DATA_W(16)) bus();
  byte_swap_arbiter #(.DATA_W(16), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .bus(bus), .busy(busy), .swap_count(swap_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (q.size() == 0) chk("unexpected_out", {16'h0, bus.out_data}, 32'hFFFF_FFFF);
      else begin
        logic [16:0] e;
        e = q.pop_front();
        chk("out_data", bus.out_data, e[15:0]);
        chk("out_id", bus.out_id, e[16]);
        exp_cnt++;
      end
    end
  end
  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1;
    bus.req0_valid = 1;
    bus.req1_valid = 1;
    @(negedge clk);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_ready0", bus.req0_ready, 0);
    chk("rst_ready1", bus.req1_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_data", bus.out_data, 0);
    @(posedge clk); #1;
    rst = 0;
    bus.req0_valid = 0;
    bus.req1_valid = 0;
    exp_cnt = 0;
    @(negedge clk);
    chk("rst_count", swap_count, 0);
  endtask
  task automatic send(input bit who, input logic [15:0] d, input bit push);
    bit got = 0;
    @(posedge clk); #1;
    if (push) q.push_back({who, d[7:0], d[15:8]});
    if (who) begin bus.req1_valid = 1; bus.req1_data = d; end
    else begin bus.req0_valid = 1; bus.req0_data = d; end
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = who ? bus.req1_ready : bus.req0_ready;
    end
    chk("accept_timeout", got, 1);
    @(posedge clk); #1;
    bus.req0_valid = 0;
    bus.req1_valid = 0;
  endtask
  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || busy) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", n < 50, 1);
    chk("swap_count", swap_count, exp_cnt);
  endtask
  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
  initial begin
    bus.req0_valid = 0; bus.req1_valid = 0;
    bus.req0_data = 0;  bus.req1_data = 0;
    bus.out_ready = 1;
    do_reset();
    // single request with exact latency
    send(0, 16'hA1B2, 1);
    @(negedge clk);
    chk("swap_out_valid", bus.out_valid, 0);
    chk("swap_busy", busy, 1);
    chk("swap_ready0", bus.req0_ready, 0);
    @(negedge clk);
    chk("done_out_valid", bus.out_valid, 1);
    @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_out_valid", bus.out_valid, 0);
    chk("single_count", swap_count, 1);
    // half identity
    send(0, 16'h00FF, 1);
    send(1, 16'hABAB, 1);
    drain();
    // backpressure in DONE with valids arriving meanwhile
    bus.out_ready = 0;
    send(1, 16'h1357, 1);
    @(negedge clk);
    chk("bp_swap_valid", bus.out_valid, 0);
    bus.req0_valid = 1; bus.req1_valid = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", bus.out_valid, 1);
      chk("bp_data", bus.out_data, 16'h5713);
      chk("bp_ready0", bus.req0_ready, 0);
      chk("bp_ready1", bus.req1_ready, 0);
      chk("bp_busy", busy, 1);
    end
    @(posedge clk); #1;
    bus.req0_valid = 0; bus.req1_valid = 0;
    bus.out_ready = 1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_idle_busy", busy, 0);
    chk("bp_idle_valid", bus.out_valid, 0);
    chk("bp_count", swap_count, exp_cnt);
    // tie after reset alternates starting with requester 0
    do_reset();
    @(posedge clk); #1;
    q.push_back({1'b0, 16'h3412});
    q.push_back({1'b1, 16'h7856});
    q.push_back({1'b0, 16'h3412});
    bus.req0_data = 16'h1234; bus.req1_data = 16'h5678;
    bus.req0_valid = 1; bus.req1_valid = 1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      chk("tie_ready0", bus.req0_ready, i == 0 || i == 6);
      chk("tie_ready1", bus.req1_ready, i == 3);
      @(posedge clk); #1;
      if (i == 6) begin bus.req0_valid = 0; bus.req1_valid = 0; end
    end
    drain();
    chk("tie_count", swap_count, 3);
    // reset during SWAP discards the word
    do_reset();
    send(0, 16'hDEAD, 0);
    rst = 1;
    bus.req0_valid = 1;
    @(negedge clk);
    chk("abort_out_valid", bus.out_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_data", bus.out_data, 0);
    chk("abort_ready0", bus.req0_ready, 0);
    @(posedge clk); #1;
    rst = 0;
    bus.req0_valid = 0;
    @(negedge clk);
    chk("abort_idle_busy", busy, 0);
    chk("abort_idle_valid", bus.out_valid, 0);
    chk("abort_count", swap_count, 0);
    repeat (6) @(negedge clk);
    chk("abort_still_idle", busy, 0);
    // counter wrap over 256 swaps
    do_reset();
    for (int i = 0; i < 256; i++) send(0, 16'($urandom), 1);
    drain();
    chk("wrap_count", swap_count, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/byte_swap_arbiter.md
BYTE_SWAP_ARBITER -- requirements
Module: byte_swap_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, giving the swap register width; it SHALL be even, and the upper and lower halves are exchanged.
REQ-002 The block SHALL have parameter CNT_W, default 8, giving the completed-swap counter width.
REQ-003 Port clk SHALL be input, width 1: the single clock; all state updates on its rising edge.
REQ-004 Port rst SHALL be input, width 1: reset, synchronous and active-high.
REQ-005 Ports req0_valid and req1_valid SHALL be inputs, width 1: requester 0/1 holds a word to swap.
REQ-006 Ports req0_data and req1_data SHALL be inputs, width DATA_W: requester 0/1 word.
REQ-007 Ports req0_ready and req1_ready SHALL be outputs, width 1: the word of requester 0/1 is accepted this cycle.
REQ-008 Port out_valid SHALL be output, width 1: out_data and out_id are valid.
REQ-009 Port out_ready SHALL be input, width 1: the consumer accepts the result.
REQ-010 Port out_data SHALL be output, width DATA_W: the swapped word.
REQ-011 Port out_id SHALL be output, width 1: the index of the requester that supplied out_data.
REQ-012 Port busy SHALL be output, width 1: high whenever the state is not IDLE.
REQ-013 Port swap_count SHALL be output, width CNT_W: the number of completed output handshakes, modulo 2^CNT_W.

Function
REQ-014 The FSM SHALL have exactly three states, IDLE, SWAP and DONE, with one shared DATA_W register temp.
REQ-015 In IDLE, the grant SHALL be: a single valid requester wins; with both valid, the requester other than last_grant wins; with neither valid, there is no grant.
REQ-016 reqN_ready SHALL be high only in IDLE, only for the granted requester, and combinationally from the valids and last_grant; at most one ready SHALL be high per cycle.
REQ-017 On an accept edge (reqN_valid and reqN_ready both high), the block SHALL set temp to reqN_data, record the id, set last_grant to N, and move to SWAP.
REQ-018 SWAP SHALL last exactly one cycle: temp becomes {temp[DATA_W/2-1:0], temp[DATA_W-1:DATA_W/2]}, both halves taken from pre-edge values, and the state moves to DONE.
REQ-019 In DONE, out_valid SHALL be 1, out_data SHALL equal temp and out_id SHALL equal the recorded id; these SHALL be held stable until the out_valid and out_ready handshake.
REQ-020 On the output handshake, the state SHALL move to IDLE and swap_count SHALL increment, wrapping from 2^CNT_W-1 to 0.
REQ-021 Latency SHALL be 2 cycles: with acceptance at edge N, out_valid is first high after edge N+1; the minimum interval between accepts is 3 cycles.
REQ-022 If out_ready is held high, DONE SHALL still last one cycle; no DONE-to-SWAP shortcut is permitted.
REQ-023 A requester dropping valid while in IDLE before being granted SHALL cause no accept and no state change.
REQ-024 Valid inputs arriving during SWAP or DONE SHALL be ignored: ready stays 0 and nothing is lost or captured.
REQ-025 out_valid SHALL be 0 in IDLE and SWAP.
REQ-026 busy SHALL be 1 in SWAP and DONE and 0 in IDLE.

Reset
REQ-027 When rst is high at a clock edge, the state SHALL become IDLE, temp 0, out_id 0, last_grant 1 (requester 0 wins the first tie) and swap_count 0.
REQ-028 While rst is high, outputs SHALL read out_valid 0, req0_ready 0, req1_ready 0, busy 0 and out_data 0.
REQ-029 Reset asserted during SWAP or DONE SHALL abort the operation: the word is discarded, swap_count is not incremented, and the block is in IDLE on the next cycle.
REQ-030 Reset SHALL take priority over any simultaneous handshake on the same edge.

Verification
REQ-031 The bench SHALL cover a single request: req0_valid=1, req0_data=16'hA1B2, out_ready=1 -> req0_ready high for 1 cycle, out_valid 2 cycles later with out_data=16'hB2A1, out_id=0, swap_count=1.
REQ-032 The bench SHALL cover a tie after reset: both valid, data 16'h1234 / 16'h5678, out_ready=1 -> outputs 16'h3412 id 0, then 16'h7856 id 1, then 16'h3412 id 0 (alternation).
REQ-033 The bench SHALL cover backpressure: out_ready=0 for 5 cycles in DONE -> out_valid and out_data held constant, both readys 0, busy=1; release -> one handshake, IDLE next cycle.
REQ-034 The bench SHALL cover reset mid-operation: rst pulsed in SWAP -> next cycle IDLE, out_valid=0, swap_count unchanged, and the pending word never appears.
REQ-035 The bench SHALL cover counter wrap: 256 back-to-back single-requester swaps with CNT_W=8 -> swap_count returns to 0, and each output is the byte-swapped input.
REQ-036 The bench SHALL cover the half-identity case: input 16'h00FF -> 16'hFF00, and input 16'hABAB -> 16'hABAB.
